// File: rtl/key_pulse_gen.sv
// Debounced key to single-cycle count-enable pulse generator with a shared filter counter.
// Optional auto-repeat while held is compiled in with `define KEY_AUTO_REPEAT_EN.
module key_pulse_gen #(
  parameter int unsigned DEB_CYC       = 1000000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic key_in,
  output logic cin,
  output logic key_state
);

  localparam int unsigned CntW = $clog2(DEB_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYC - 1);

  // Repeat parameters are range-checked even when unused so enabling the feature is safe.
  if (DEB_CYC < 2 || DEB_CYC > 24'hFF_FFFF || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
    $error("key_pulse_gen: parameter out of legal range");
  end

  typedef enum logic [1:0] {StIdle, StPressFilt, StDown, StRelFilt} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync1_q, key_s;
  logic            cin_q, cin_d;
  logic            key_state_q, key_state_d;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax);

  logic [RepW-1:0] rep_q, rep_d, rep_lim;
  logic            rep_arm_q, rep_arm_d;

  // First interval is the initial delay, every later one the repeat period.
  assign rep_lim = rep_arm_q ? RepW'(REPEAT_PERIOD - 1) : RepW'(REPEAT_DELAY - 1);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rep_q     <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_q     <= rep_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`endif

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      key_s   <= 1'b1;
    end else begin
      sync1_q <= key_in;
      key_s   <= sync1_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cin_q       <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cin_q       <= cin_d;
      key_state_q <= key_state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cin_d       = 1'b0;
    key_state_d = key_state_q;
`ifdef KEY_AUTO_REPEAT_EN
    rep_d       = rep_q;
    rep_arm_d   = rep_arm_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d = StPressFilt;
          cnt_d   = '0;
        end
      end
      StPressFilt: begin
        if (key_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d     = StDown;
          cin_d       = 1'b1;
          key_state_d = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
          rep_d       = '0;
          rep_arm_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDown: begin
        if (key_s) begin
          state_d = StRelFilt;
          cnt_d   = '0;
        end else begin
`ifdef KEY_AUTO_REPEAT_EN
          if (rep_q == rep_lim) begin
            cin_d     = 1'b1;
            rep_d     = '0;
            rep_arm_d = 1'b1;
          end else begin
            rep_d = rep_q + RepW'(1);
          end
`endif
        end
      end
      StRelFilt: begin
        // Bounce back to DOWN keeps the repeat counter where it was.
        if (!key_s) begin
          state_d = StDown;
        end else if (cnt_q == CntMax) begin
          state_d     = StIdle;
          key_state_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cin       = cin_q;
  assign key_state = key_state_q;

endmodule
